// File: rtl/lsu_dtcm_master_pkg.sv
// Shared definitions for the LSU-side DTCM initiator: bus widths, size codes,
// FSM state encodings and the request-decode helpers used at request accept.
package lsu_dtcm_master_pkg;

   localparam int DTCM_ADDR_WIDTH = 16;
   localparam int DTCM_RAM_DW     = 32;
   localparam int DTCM_RAM_MW     = DTCM_RAM_DW / 8;

   typedef enum logic [1:0] {
      LSU_SIZE_B = 2'b00,
      LSU_SIZE_H = 2'b01,
      LSU_SIZE_W = 2'b10,
      LSU_SIZE_X = 2'b11
   } lsu_size_e;

   typedef enum logic [1:0] {
      LSU_ST_IDLE = 2'b00,
      LSU_ST_CMD  = 2'b01,
      LSU_ST_WAIT = 2'b10,
      LSU_ST_RESP = 2'b11
   } lsu_state_e;

   // Legal size and naturally aligned for that size.
   function automatic logic lsu_req_ok(input lsu_size_e size, input logic [1:0] off);
      case (size)
         LSU_SIZE_B: return 1'b1;
         LSU_SIZE_H: return ~off[0];
         LSU_SIZE_W: return (off == 2'b00);
         default:    return 1'b0;
      endcase
   endfunction

   // Byte-lane write enables for a store of the given size at the given offset.
   function automatic logic [DTCM_RAM_MW-1:0] lsu_wmask(input lsu_size_e size, input logic [1:0] off);
      case (size)
         LSU_SIZE_B: return 4'b0001 << off;
         LSU_SIZE_H: return 4'b0011 << off;
         default:    return 4'b1111;
      endcase
   endfunction

   // Replicate the LSB-aligned store data across every lane it could land in,
   // so the mask alone selects the written bytes.
   function automatic logic [DTCM_RAM_DW-1:0] lsu_wdata(input lsu_size_e size, input logic [31:0] wdata);
      case (size)
         LSU_SIZE_B: return {4{wdata[7:0]}};
         LSU_SIZE_H: return {2{wdata[15:0]}};
         default:    return wdata;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: picks the addressed byte/half out of the raw DTCM word and
// sign- or zero-extends it to 32 bits. Words pass through unchanged.
module lsu_load_align
   import lsu_dtcm_master_pkg::*;
(
   input  logic [DTCM_RAM_DW-1:0] rdata_i,
   input  logic [1:0]             off_i,
   input  lsu_size_e              size_i,
   input  logic                   unsigned_i,
   output logic [31:0]            result_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select and extension.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, otherwise
      // a path that skips the assignment infers a latch.
      byte_sel = rdata_i[{off_i, 3'b000} +: 8];
      half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];
      result_o = rdata_i;
      case (size_i)
         LSU_SIZE_B: result_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         LSU_SIZE_H: result_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         default:    result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_dtcm_master.sv
// LSU-side initiator of the lsu2dtcm cmd/rsp interface. One outstanding access:
// accept from EXU, check alignment, issue one DTCM command, wait for the DTCM
// response, return extended load data or a store ack. Misaligned/illegal
// requests are answered with err=1 and never reach the DTCM.
module lsu_dtcm_master
   import lsu_dtcm_master_pkg::*;
#(
   parameter int ADDR_W = DTCM_ADDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   exu2lsu_req_valid,
   output logic                   exu2lsu_req_ready,
   input  logic                   exu2lsu_req_load,
   input  logic [31:0]            exu2lsu_req_addr,
   input  logic [1:0]             exu2lsu_req_size,
   input  logic                   exu2lsu_req_unsigned,
   input  logic [31:0]            exu2lsu_req_wdata,
   output logic                   lsu2exu_rsp_valid,
   input  logic                   lsu2exu_rsp_ready,
   output logic [31:0]            lsu2exu_rsp_rdata,
   output logic                   lsu2exu_rsp_err,
   output logic                   lsu2dtcm_cmd_valid,
   input  logic                   lsu2dtcm_cmd_ready,
   output logic                   lsu2dtcm_cmd_read,
   output logic [ADDR_W-1:0]      lsu2dtcm_cmd_addr,
   output logic [DTCM_RAM_MW-1:0] lsu2dtcm_cmd_wmask,
   output logic [DTCM_RAM_DW-1:0] lsu2dtcm_cmd_wdata,
   input  logic                   lsu2dtcm_rsp_valid,
   output logic                   lsu2dtcm_rsp_ready,
   input  logic [DTCM_RAM_DW-1:0] lsu2dtcm_rsp_rdata
);

   lsu_state_e             state_q;
   logic                   req_ready_q;
   logic                   cmd_valid_q;
   logic                   cmd_read_q;
   logic [ADDR_W-1:0]      cmd_addr_q;
   logic [DTCM_RAM_MW-1:0] cmd_wmask_q;
   logic [DTCM_RAM_DW-1:0] cmd_wdata_q;
   logic                   dtcm_rsp_ready_q;
   logic                   rsp_valid_q;
   logic                   rsp_err_q;
   logic [31:0]            rsp_rdata_q;

   // Request fields the load aligner needs once the DTCM word comes back.
   logic                   load_q;
   logic                   unsigned_q;
   lsu_size_e              size_q;
   logic [1:0]             off_q;

   lsu_size_e              req_size;
   logic                   req_ok;
   logic [31:0]            load_ext;
   logic                   unused_addr_hi;

   assign req_size = lsu_size_e'(exu2lsu_req_size);
   assign req_ok   = lsu_req_ok(req_size, exu2lsu_req_addr[1:0]);

   // Address bits above the DTCM window carry no meaning for this port.
   assign unused_addr_hi = ^exu2lsu_req_addr[31:ADDR_W];

   lsu_load_align u_load_align (
      .rdata_i    (lsu2dtcm_rsp_rdata),
      .off_i      (off_q),
      .size_i     (size_q),
      .unsigned_i (unsigned_q),
      .result_o   (load_ext)
   );

   // Transaction FSM with every interface output registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= LSU_ST_IDLE;
         req_ready_q      <= 1'b1;
         cmd_valid_q      <= 1'b0;
         cmd_read_q       <= 1'b0;
         cmd_addr_q       <= '0;
         cmd_wmask_q      <= '0;
         cmd_wdata_q      <= '0;
         dtcm_rsp_ready_q <= 1'b0;
         rsp_valid_q      <= 1'b0;
         rsp_err_q        <= 1'b0;
         rsp_rdata_q      <= '0;
         load_q           <= 1'b0;
         unsigned_q       <= 1'b0;
         size_q           <= LSU_SIZE_B;
         off_q            <= 2'b00;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every register
         // here sees the pre-edge values, regardless of statement order.
         case (state_q)
            LSU_ST_IDLE: begin
               if (exu2lsu_req_valid) begin
                  req_ready_q <= 1'b0;
                  load_q      <= exu2lsu_req_load;
                  unsigned_q  <= exu2lsu_req_unsigned;
                  size_q      <= req_size;
                  off_q       <= exu2lsu_req_addr[1:0];
                  if (req_ok) begin
                     state_q     <= LSU_ST_CMD;
                     cmd_valid_q <= 1'b1;
                     cmd_read_q  <= exu2lsu_req_load;
                     cmd_addr_q  <= {exu2lsu_req_addr[ADDR_W-1:2], 2'b00};
                     cmd_wmask_q <= exu2lsu_req_load ? '0 : lsu_wmask(req_size, exu2lsu_req_addr[1:0]);
                     cmd_wdata_q <= exu2lsu_req_load ? '0 : lsu_wdata(req_size, exu2lsu_req_wdata);
                  end else begin
                     state_q     <= LSU_ST_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end
               end
            end
            LSU_ST_CMD: begin
               if (lsu2dtcm_cmd_ready) begin
                  state_q          <= LSU_ST_WAIT;
                  cmd_valid_q      <= 1'b0;
                  dtcm_rsp_ready_q <= 1'b1;
               end
            end
            LSU_ST_WAIT: begin
               if (lsu2dtcm_rsp_valid) begin
                  state_q          <= LSU_ST_RESP;
                  dtcm_rsp_ready_q <= 1'b0;
                  rsp_valid_q      <= 1'b1;
                  rsp_err_q        <= 1'b0;
                  rsp_rdata_q      <= load_q ? load_ext : '0;
               end
            end
            LSU_ST_RESP: begin
               if (lsu2exu_rsp_ready) begin
                  state_q     <= LSU_ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= '0;
                  req_ready_q <= 1'b1;
               end
            end
            default: state_q <= LSU_ST_IDLE;
         endcase
      end
   end

   assign exu2lsu_req_ready  = req_ready_q;
   assign lsu2exu_rsp_valid  = rsp_valid_q;
   assign lsu2exu_rsp_rdata  = rsp_rdata_q;
   assign lsu2exu_rsp_err    = rsp_err_q;
   assign lsu2dtcm_cmd_valid = cmd_valid_q;
   assign lsu2dtcm_cmd_read  = cmd_read_q;
   assign lsu2dtcm_cmd_addr  = cmd_addr_q;
   assign lsu2dtcm_cmd_wmask = cmd_wmask_q;
   assign lsu2dtcm_cmd_wdata = cmd_wdata_q;
   assign lsu2dtcm_rsp_ready = dtcm_rsp_ready_q;

endmodule

// File: tb/tb_lsu_dtcm_master.sv
// Self-checking bench for lsu_dtcm_master: directed cases plus randomized
// transactions compared against an arithmetic model of the access rules.
module tb_lsu_dtcm_master;

   localparam int AW = 16;

   typedef struct {
      logic          err;
      logic [3:0]    mask;
      logic [31:0]   wdata;
      logic [AW-1:0] addr;
      logic [31:0]   rdata;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          exu2lsu_req_valid;
   logic          exu2lsu_req_ready;
   logic          exu2lsu_req_load;
   logic [31:0]   exu2lsu_req_addr;
   logic [1:0]    exu2lsu_req_size;
   logic          exu2lsu_req_unsigned;
   logic [31:0]   exu2lsu_req_wdata;
   logic          lsu2exu_rsp_valid;
   logic          lsu2exu_rsp_ready;
   logic [31:0]   lsu2exu_rsp_rdata;
   logic          lsu2exu_rsp_err;
   logic          lsu2dtcm_cmd_valid;
   logic          lsu2dtcm_cmd_ready;
   logic          lsu2dtcm_cmd_read;
   logic [AW-1:0] lsu2dtcm_cmd_addr;
   logic [3:0]    lsu2dtcm_cmd_wmask;
   logic [31:0]   lsu2dtcm_cmd_wdata;
   logic          lsu2dtcm_rsp_valid;
   logic          lsu2dtcm_rsp_ready;
   logic [31:0]   lsu2dtcm_rsp_rdata;

   int n_checks = 0;
   int n_fails  = 0;

   lsu_dtcm_master #(.ADDR_W(AW)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .exu2lsu_req_valid    (exu2lsu_req_valid),
      .exu2lsu_req_ready    (exu2lsu_req_ready),
      .exu2lsu_req_load     (exu2lsu_req_load),
      .exu2lsu_req_addr     (exu2lsu_req_addr),
      .exu2lsu_req_size     (exu2lsu_req_size),
      .exu2lsu_req_unsigned (exu2lsu_req_unsigned),
      .exu2lsu_req_wdata    (exu2lsu_req_wdata),
      .lsu2exu_rsp_valid    (lsu2exu_rsp_valid),
      .lsu2exu_rsp_ready    (lsu2exu_rsp_ready),
      .lsu2exu_rsp_rdata    (lsu2exu_rsp_rdata),
      .lsu2exu_rsp_err      (lsu2exu_rsp_err),
      .lsu2dtcm_cmd_valid   (lsu2dtcm_cmd_valid),
      .lsu2dtcm_cmd_ready   (lsu2dtcm_cmd_ready),
      .lsu2dtcm_cmd_read    (lsu2dtcm_cmd_read),
      .lsu2dtcm_cmd_addr    (lsu2dtcm_cmd_addr),
      .lsu2dtcm_cmd_wmask   (lsu2dtcm_cmd_wmask),
      .lsu2dtcm_cmd_wdata   (lsu2dtcm_cmd_wdata),
      .lsu2dtcm_rsp_valid   (lsu2dtcm_rsp_valid),
      .lsu2dtcm_rsp_ready   (lsu2dtcm_rsp_ready),
      .lsu2dtcm_rsp_rdata   (lsu2dtcm_rsp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected DTCM command and EXU response for one request, from the access rules.
   function automatic exp_t model(input logic ld, input logic [31:0] addr, input logic [1:0] size,
                                  input logic uns, input logic [31:0] wd, input logic [31:0] dw);
      exp_t   e;
      longint one, off, nb, v, acc, base;
      one  = 1;
      off  = longint'({32'b0, addr}) % 4;
      nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
      e.err = (nb == 0) ? 1'b1 : ((off % nb) != 0);
      base = (longint'({32'b0, addr}) - off) % (one << AW);
      e.addr  = base[AW-1:0];
      e.mask  = '0;
      e.wdata = '0;
      e.rdata = '0;
      if (!e.err && !ld) begin
         v = ((one << nb) - 1) << off;
         e.mask = v[3:0];
         v   = longint'({32'b0, wd}) % (one << (8 * nb));
         acc = 0;
         for (int i = 0; i < 4 / nb; i++) acc = acc + (v << (8 * nb * i));
         e.wdata = acc[31:0];
      end
      if (!e.err && ld) begin
         v = (longint'({32'b0, dw}) >> (8 * off)) % (one << (8 * nb));
         if (!uns && nb < 4 && v >= (one << (8 * nb - 1))) v = v - (one << (8 * nb));
         e.rdata = v[31:0];
      end
      return e;
   endfunction

   // Drive one EXU request through to its response, acting as DTCM and EXU.
   task automatic run_txn(input logic ld, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wd, input logic [31:0] dword,
                          input int cmd_stall, input int rsp_stall);
      exp_t e;
      e = model(ld, addr, size, uns, wd, dword);
      exu2lsu_req_valid    = 1'b1;
      exu2lsu_req_load     = ld;
      exu2lsu_req_addr     = addr;
      exu2lsu_req_size     = size;
      exu2lsu_req_unsigned = uns;
      exu2lsu_req_wdata    = wd;
      n_checks++; if (exu2lsu_req_ready !== 1'b1) begin n_fails++; $display("FAIL req_ready_idle: got %b expected 1", exu2lsu_req_ready); end
      step();
      if (!e.err) begin
         // Request inputs change while busy; the captured request must not.
         exu2lsu_req_addr  = $urandom;
         exu2lsu_req_wdata = $urandom;
         exu2lsu_req_load  = ~ld;
         exu2lsu_req_size  = ~size;
         for (int c = 0; c <= cmd_stall; c++) begin
            lsu2dtcm_cmd_ready = (c == cmd_stall);
            lsu2dtcm_rsp_valid = (c < cmd_stall);
            lsu2dtcm_rsp_rdata = $urandom;
            n_checks++; if (lsu2dtcm_cmd_valid !== 1'b1) begin n_fails++; $display("FAIL cmd_valid c=%0d: got %b expected 1", c, lsu2dtcm_cmd_valid); end
            n_checks++; if (lsu2dtcm_cmd_read !== ld) begin n_fails++; $display("FAIL cmd_read: got %b expected %b", lsu2dtcm_cmd_read, ld); end
            n_checks++; if (lsu2dtcm_cmd_addr !== e.addr) begin n_fails++; $display("FAIL cmd_addr: got %h expected %h", lsu2dtcm_cmd_addr, e.addr); end
            n_checks++; if (lsu2dtcm_cmd_wmask !== e.mask) begin n_fails++; $display("FAIL cmd_wmask: got %b expected %b", lsu2dtcm_cmd_wmask, e.mask); end
            if (!ld) begin
               n_checks++; if (lsu2dtcm_cmd_wdata !== e.wdata) begin n_fails++; $display("FAIL cmd_wdata: got %h expected %h", lsu2dtcm_cmd_wdata, e.wdata); end
            end
            n_checks++; if (exu2lsu_req_ready !== 1'b0 || lsu2exu_rsp_valid !== 1'b0) begin n_fails++; $display("FAIL busy_cmd: got ready=%b rsp_valid=%b expected 0 0", exu2lsu_req_ready, lsu2exu_rsp_valid); end
            step();
         end
         lsu2dtcm_cmd_ready = 1'b1;
         exu2lsu_req_valid  = 1'b0;
         n_checks++; if (lsu2dtcm_cmd_valid !== 1'b0 || lsu2dtcm_rsp_ready !== 1'b1) begin n_fails++; $display("FAIL wait_rsp: got cmd_valid=%b rsp_ready=%b expected 0 1", lsu2dtcm_cmd_valid, lsu2dtcm_rsp_ready); end
         lsu2dtcm_rsp_valid = 1'b1;
         lsu2dtcm_rsp_rdata = dword;
         step();
      end else begin
         exu2lsu_req_valid = 1'b0;
      end
      for (int c = 0; c <= rsp_stall; c++) begin
         lsu2exu_rsp_ready  = (c == rsp_stall);
         lsu2dtcm_rsp_valid = (c < rsp_stall);
         lsu2dtcm_rsp_rdata = $urandom;
         n_checks++; if (lsu2exu_rsp_valid !== 1'b1) begin n_fails++; $display("FAIL rsp_valid c=%0d: got %b expected 1", c, lsu2exu_rsp_valid); end
         n_checks++; if (lsu2exu_rsp_err !== e.err) begin n_fails++; $display("FAIL rsp_err: got %b expected %b", lsu2exu_rsp_err, e.err); end
         n_checks++; if (lsu2exu_rsp_rdata !== e.rdata) begin n_fails++; $display("FAIL rsp_rdata: got %h expected %h", lsu2exu_rsp_rdata, e.rdata); end
         n_checks++; if (lsu2dtcm_cmd_valid !== 1'b0 || lsu2dtcm_rsp_ready !== 1'b0) begin n_fails++; $display("FAIL resp_quiet: got cmd_valid=%b rsp_ready=%b expected 0 0", lsu2dtcm_cmd_valid, lsu2dtcm_rsp_ready); end
         step();
      end
      lsu2exu_rsp_ready  = 1'b0;
      lsu2dtcm_rsp_valid = 1'b0;
      n_checks++; if (lsu2exu_rsp_valid !== 1'b0 || exu2lsu_req_ready !== 1'b1) begin n_fails++; $display("FAIL post_resp: got rsp_valid=%b req_ready=%b expected 0 1", lsu2exu_rsp_valid, exu2lsu_req_ready); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      exu2lsu_req_valid = 1'b0; exu2lsu_req_load = 1'b0; exu2lsu_req_addr = '0;
      exu2lsu_req_size = 2'b00; exu2lsu_req_unsigned = 1'b0; exu2lsu_req_wdata = '0;
      lsu2exu_rsp_ready = 1'b0; lsu2dtcm_cmd_ready = 1'b1; lsu2dtcm_rsp_valid = 1'b0; lsu2dtcm_rsp_rdata = '0;
      step();
      n_checks++; if (exu2lsu_req_ready !== 1'b1) begin n_fails++; $display("FAIL reset_req_ready: got %b expected 1", exu2lsu_req_ready); end
      n_checks++; if (lsu2exu_rsp_valid !== 1'b0 || lsu2exu_rsp_err !== 1'b0 || lsu2exu_rsp_rdata !== 32'h0) begin n_fails++; $display("FAIL reset_rsp: got v=%b e=%b d=%h expected 0 0 0", lsu2exu_rsp_valid, lsu2exu_rsp_err, lsu2exu_rsp_rdata); end
      n_checks++; if (lsu2dtcm_cmd_valid !== 1'b0 || lsu2dtcm_rsp_ready !== 1'b0 || lsu2dtcm_cmd_read !== 1'b0) begin n_fails++; $display("FAIL reset_dtcm: got cv=%b rr=%b rd=%b expected 0 0 0", lsu2dtcm_cmd_valid, lsu2dtcm_rsp_ready, lsu2dtcm_cmd_read); end
      n_checks++; if (lsu2dtcm_cmd_addr !== '0 || lsu2dtcm_cmd_wmask !== 4'h0 || lsu2dtcm_cmd_wdata !== 32'h0) begin n_fails++; $display("FAIL reset_cmd_fields: got a=%h m=%b d=%h expected 0", lsu2dtcm_cmd_addr, lsu2dtcm_cmd_wmask, lsu2dtcm_cmd_wdata); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_store_word();
      run_txn(1'b0, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 0, 0);
   endtask

   task automatic test_load_byte();
      run_txn(1'b1, 32'h13, 2'b00, 1'b0, 32'h0, 32'h80FF_1234, 0, 0);
      run_txn(1'b1, 32'h13, 2'b00, 1'b1, 32'h0, 32'h80FF_1234, 0, 0);
      run_txn(1'b1, 32'h12, 2'b01, 1'b0, 32'h0, 32'h80FF_1234, 0, 0);
      run_txn(1'b1, 32'h10, 2'b10, 1'b1, 32'h0, 32'h80FF_1234, 0, 0);
   endtask

   task automatic test_half_store();
      run_txn(1'b0, 32'h22, 2'b01, 1'b0, 32'h0000_ABCD, 32'h0, 0, 0);
      run_txn(1'b0, 32'h21, 2'b00, 1'b0, 32'h1234_5677, 32'h0, 0, 0);
   endtask

   task automatic test_errors();
      run_txn(1'b1, 32'h21, 2'b01, 1'b0, 32'h0, 32'hFFFF_FFFF, 0, 0);
      run_txn(1'b0, 32'h10, 2'b11, 1'b0, 32'h5555_5555, 32'h0, 0, 1);
      run_txn(1'b1, 32'h42, 2'b10, 1'b0, 32'h0, 32'h0, 0, 0);
   endtask

   task automatic test_stalls();
      run_txn(1'b0, 32'h22, 2'b01, 1'b0, 32'h0000_ABCD, 32'h0, 3, 2);
      run_txn(1'b1, 32'h31, 2'b00, 1'b0, 32'h0, 32'h00C3_7F00, 3, 2);
   endtask

   task automatic test_back_to_back();
      run_txn(1'b0, 32'h100, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0, 0, 0);
      run_txn(1'b1, 32'h102, 2'b01, 1'b1, 32'h0, 32'h8001_7FFE, 0, 0);
      run_txn(1'b1, 32'h103, 2'b01, 1'b0, 32'h0, 32'h0, 0, 0);
      run_txn(1'b1, 32'h101, 2'b00, 1'b0, 32'h0, 32'h0000_9900, 0, 0);
   endtask

   task automatic test_random();
      logic [31:0] r, a, w, d;
      for (int i = 0; i < 60; i++) begin
         r = $urandom; a = $urandom; w = $urandom; d = $urandom;
         run_txn(r[0], a, r[2:1], r[3], w, d, int'(r[5:4]) % 3, int'(r[7:6]) % 3);
      end
   endtask

   task automatic test_reset_mid();
      exu2lsu_req_valid = 1'b1; exu2lsu_req_load = 1'b1; exu2lsu_req_addr = 32'h40;
      exu2lsu_req_size = 2'b10; exu2lsu_req_unsigned = 1'b0;
      lsu2dtcm_cmd_ready = 1'b1;
      step();
      exu2lsu_req_valid = 1'b0;
      step();
      n_checks++; if (lsu2dtcm_rsp_ready !== 1'b1) begin n_fails++; $display("FAIL mid_in_wait: got rsp_ready=%b expected 1", lsu2dtcm_rsp_ready); end
      rst = 1'b1;
      #1;
      n_checks++; if (lsu2dtcm_rsp_ready !== 1'b0 || lsu2dtcm_cmd_valid !== 1'b0 || exu2lsu_req_ready !== 1'b1) begin n_fails++; $display("FAIL mid_async_reset: got rr=%b cv=%b rq=%b expected 0 0 1", lsu2dtcm_rsp_ready, lsu2dtcm_cmd_valid, exu2lsu_req_ready); end
      step();
      rst = 1'b0;
      lsu2dtcm_rsp_valid = 1'b1;
      lsu2dtcm_rsp_rdata = 32'h1357_9BDF;
      for (int c = 0; c < 3; c++) begin
         step();
         n_checks++; if (lsu2exu_rsp_valid !== 1'b0 || exu2lsu_req_ready !== 1'b1 || lsu2dtcm_cmd_valid !== 1'b0) begin n_fails++; $display("FAIL late_rsp_ignored: got rv=%b rq=%b cv=%b expected 0 1 0", lsu2exu_rsp_valid, exu2lsu_req_ready, lsu2dtcm_cmd_valid); end
      end
      lsu2dtcm_rsp_valid = 1'b0;
      run_txn(1'b1, 32'h46, 2'b01, 1'b0, 32'h0, 32'h8765_4321, 0, 0);
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_load_byte();
      test_half_store();
      test_errors();
      test_stalls();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
